// File: rtl/mips_lsu_pkg.sv
// Shared types and lane helpers for the MIPS load/store unit.
// The optional LSU_STATS_EN build adds the statistics counters to mips_lsu_mem_master.
package mips_lsu_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned HALF_W    = 16;
  localparam int unsigned LANE_SH_W = 5;
  localparam int unsigned STAT_W    = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Big-endian: byte offset 0 sits in bits 31:24, so the shift is (3 - off) * 8.
  function automatic logic [LANE_SH_W-1:0] byte_shift(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

  // Half offset 0 sits in bits 31:16, offset 2 in bits 15:0.
  function automatic logic [LANE_SH_W-1:0] half_shift(input logic off_hi);
    return {~off_hi, 4'b0000};
  endfunction

endpackage

// File: rtl/mips_lsu_lane.sv
// Combinational lane extraction (with sign/zero extension) and sub-word store merge.
module mips_lsu_lane
  import mips_lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_val_c,
  output logic [DATA_W-1:0] merged_c
);

  logic [LANE_SH_W-1:0] bsh_c;
  logic [LANE_SH_W-1:0] hsh_c;
  logic [BYTE_W-1:0]    byte_c;
  logic [HALF_W-1:0]    half_c;

  always_comb begin
    bsh_c      = byte_shift(offset);
    hsh_c      = half_shift(offset[1]);
    byte_c     = BYTE_W'(word >> bsh_c);
    half_c     = HALF_W'(word >> hsh_c);
    load_val_c = word;
    merged_c   = wdata;
    case (size)
      SIZE_BYTE: begin
        load_val_c = {{(DATA_W-BYTE_W){is_signed & byte_c[BYTE_W-1]}}, byte_c};
        merged_c   = (word & ~(DATA_W'(8'hFF) << bsh_c))
                   | (DATA_W'(wdata[BYTE_W-1:0]) << bsh_c);
      end
      SIZE_HALF: begin
        load_val_c = {{(DATA_W-HALF_W){is_signed & half_c[HALF_W-1]}}, half_c};
        merged_c   = (word & ~(DATA_W'(16'hFFFF) << hsh_c))
                   | (DATA_W'(wdata[HALF_W-1:0]) << hsh_c);
      end
      default: begin
        load_val_c = word;
        merged_c   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mips_lsu_mem_master.sv
// Load/store unit driving word-wide memory strobes; sub-word stores use read-modify-write.
// Define LSU_STATS_EN to add the stat_loads/stat_stores/stat_errs counters.
module mips_lsu_mem_master
  import mips_lsu_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 1,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       write_data,
  output logic              signal_mem_read,
  output logic              signal_mem_write,
  input  logic [31:0]       read_data
`ifdef LSU_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_loads,
  output logic [STAT_W-1:0] stat_stores,
  output logic [STAT_W-1:0] stat_errs
`endif
);

  localparam int unsigned CNT_W = 3;

  lsu_state_t        state, state_nxt;
  logic [CNT_W-1:0]  rd_cnt, rd_cnt_nxt;
  logic              op_write, op_write_nxt;
  logic [1:0]        op_size, op_size_nxt;
  logic              op_signed, op_signed_nxt;
  logic [1:0]        op_off, op_off_nxt;
  logic [31:0]       op_wdata, op_wdata_nxt;
  logic [ADDR_W-1:0] address_nxt;
  logic [31:0]       write_data_nxt, resp_rdata_nxt;
  logic              rd_nxt, wr_nxt, resp_valid_nxt, resp_err_nxt;
  logic              bad_c, rd_last_c;
  logic [31:0]       load_val_c, merged_c;

  assign req_ready = (state == IDLE);
  assign rd_last_c = (rd_cnt == CNT_W'(MEM_RD_LAT - 1));

  // Misaligned or illegal-size requests never reach memory.
  always_comb begin
    bad_c = 1'b0;
    case (req_size)
      SIZE_BYTE: bad_c = 1'b0;
      SIZE_HALF: bad_c = req_addr[0];
      SIZE_WORD: bad_c = |req_addr[1:0];
      default:   bad_c = 1'b1;
    endcase
  end

  mips_lsu_lane u_lane (
    .word       (read_data),
    .offset     (op_off),
    .size       (op_size),
    .is_signed  (op_signed),
    .wdata      (op_wdata),
    .load_val_c (load_val_c),
    .merged_c   (merged_c)
  );

  always_comb begin
    state_nxt      = state;
    rd_cnt_nxt     = rd_cnt;
    op_write_nxt   = op_write;
    op_size_nxt    = op_size;
    op_signed_nxt  = op_signed;
    op_off_nxt     = op_off;
    op_wdata_nxt   = op_wdata;
    address_nxt    = address;
    write_data_nxt = write_data;
    resp_rdata_nxt = resp_rdata;
    rd_nxt         = 1'b0;
    wr_nxt         = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          op_write_nxt   = req_write;
          op_size_nxt    = req_size;
          op_signed_nxt  = req_signed;
          op_off_nxt     = req_addr[1:0];
          op_wdata_nxt   = req_wdata;
          resp_rdata_nxt = '0;
          if (bad_c) begin
            state_nxt      = RESP;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
          end else begin
            address_nxt = {req_addr[ADDR_W-1:2], 2'b00};
            if (req_write && req_size == SIZE_WORD) begin
              state_nxt      = WRITE;
              wr_nxt         = 1'b1;
              write_data_nxt = req_wdata;
            end else begin
              state_nxt  = READ;
              rd_nxt     = 1'b1;
              rd_cnt_nxt = '0;
            end
          end
        end
      end
      READ: begin
        if (rd_last_c) begin
          if (op_write) begin
            state_nxt      = WRITE;
            wr_nxt         = 1'b1;
            write_data_nxt = merged_c;
          end else begin
            state_nxt      = RESP;
            resp_valid_nxt = 1'b1;
            resp_rdata_nxt = load_val_c;
          end
        end else begin
          rd_cnt_nxt = rd_cnt + CNT_W'(1);
          rd_nxt     = 1'b1;
        end
      end
      WRITE: begin
        state_nxt      = RESP;
        resp_valid_nxt = 1'b1;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rd_cnt           <= '0;
      op_write         <= 1'b0;
      op_size          <= SIZE_BYTE;
      op_signed        <= 1'b0;
      op_off           <= '0;
      op_wdata         <= '0;
      address          <= '0;
      write_data       <= '0;
      resp_rdata       <= '0;
      signal_mem_read  <= 1'b0;
      signal_mem_write <= 1'b0;
      resp_valid       <= 1'b0;
      resp_err         <= 1'b0;
    end else begin
      state            <= state_nxt;
      rd_cnt           <= rd_cnt_nxt;
      op_write         <= op_write_nxt;
      op_size          <= op_size_nxt;
      op_signed        <= op_signed_nxt;
      op_off           <= op_off_nxt;
      op_wdata         <= op_wdata_nxt;
      address          <= address_nxt;
      write_data       <= write_data_nxt;
      resp_rdata       <= resp_rdata_nxt;
      signal_mem_read  <= rd_nxt;
      signal_mem_write <= wr_nxt;
      resp_valid       <= resp_valid_nxt;
      resp_err         <= resp_err_nxt;
    end
  end

`ifdef LSU_STATS_EN
  // Completion counters, bumped once per RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (state == RESP) begin
      if (resp_err)      stat_errs   <= stat_errs + STAT_W'(1);
      else if (op_write) stat_stores <= stat_stores + STAT_W'(1);
      else               stat_loads  <= stat_loads + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mips_lsu_mem_master.sv
// Directed scoreboard bench for mips_lsu_mem_master with a word-addressed memory model.
module tb_mips_lsu_mem_master;

  localparam int unsigned LAT    = 3;
  localparam int unsigned ADDR_W = 32;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       tag;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_write, req_signed;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data, read_data;
  logic              signal_mem_read, signal_mem_write;
`ifdef LSU_STATS_EN
  logic [31:0]       stat_loads, stat_stores, stat_errs;
`endif

  logic [31:0] mem [0:63];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rd_seen = 0;
  int          wr_seen = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;

  mips_lsu_mem_master #(.MEM_RD_LAT(LAT), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .address          (address),
    .write_data       (write_data),
    .signal_mem_read  (signal_mem_read),
    .signal_mem_write (signal_mem_write),
    .read_data        (read_data)
`ifdef LSU_STATS_EN
    ,
    .stat_loads       (stat_loads),
    .stat_stores      (stat_stores),
    .stat_errs        (stat_errs)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign read_data = mem[address[7:2]];
  always @(posedge clk) if (signal_mem_write) mem[address[7:2]] <= write_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Strobe monitor and response scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("strobe_excl", {31'b0, signal_mem_read & signal_mem_write}, 32'h0);
      if (signal_mem_read) begin
        rd_seen++;
        last_addr = address;
      end
      if (signal_mem_write) begin
        wr_seen++;
        last_addr  = address;
        last_wdata = write_data;
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", {31'b0, resp_valid}, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.tag, "_rdata"}, resp_rdata, e.rdata);
          chk({e.tag, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
          chk({e.tag, "_lat"}, 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic txn(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_err, input int lat, input int n_rd, input int n_wr,
                     input logic [31:0] exp_wd);
    exp_t e;
    logic [31:0] al;
    al = {a[31:2], 2'b00};
    @(negedge clk);
    rd_seen = 0;
    wr_seen = 0;
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + lat - 1; e.tag = tag;
    sb.push_back(e);
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      chk({tag, "_timeout"}, 32'(sb.size()), 32'h0);
      sb.delete();
    end
    chk({tag, "_nrd"}, 32'(rd_seen), 32'(n_rd));
    chk({tag, "_nwr"}, 32'(wr_seen), 32'(n_wr));
    if (n_rd + n_wr > 0) chk({tag, "_addr"}, last_addr, al);
    if (n_wr > 0) chk({tag, "_wdata"}, last_wdata, exp_wd);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[4] = 32'hA5B6C7D8;
    mem[2] = 32'h11223344;
    mem[3] = 32'h00000001;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_address", address, 32'h0);
    chk("rst_wdata", write_data, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_strobes", {30'b0, signal_mem_read, signal_mem_write}, 32'h0);
    chk("rst_resp", {30'b0, resp_valid, resp_err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_idle", {31'b0, req_ready}, 32'h1);

    txn("lb_s",   1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'hFFFFFFA5, 1'b0, LAT+1, LAT, 0, 32'h0);
    txn("lbu",    1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h000000A5, 1'b0, LAT+1, LAT, 0, 32'h0);
    txn("lbu_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h000000B6, 1'b0, LAT+1, LAT, 0, 32'h0);
    txn("lb_13",  1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFFD8, 1'b0, LAT+1, LAT, 0, 32'h0);
    txn("lhu",    1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000C7D8, 1'b0, LAT+1, LAT, 0, 32'h0);
    txn("lh_s",   1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFFC7D8, 1'b0, LAT+1, LAT, 0, 32'h0);
    txn("lh_s0",  1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'hFFFFA5B6, 1'b0, LAT+1, LAT, 0, 32'h0);
    txn("lw",     1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h11223344, 1'b0, LAT+1, LAT, 0, 32'h0);
    txn("lw_sgn", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'hA5B6C7D8, 1'b0, LAT+1, LAT, 0, 32'h0);
    txn("sb",     1'b1, 2'b00, 1'b0, 32'h0D, 32'hEE, 32'h0, 1'b0, LAT+2, LAT, 1, 32'h00EE0001);
    txn("lw_sb",  1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h00EE0001, 1'b0, LAT+1, LAT, 0, 32'h0);
    txn("sh",     1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234ABCD, 32'h0, 1'b0, LAT+2, LAT, 1, 32'h00EEABCD);
    txn("lw_sh",  1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h00EEABCD, 1'b0, LAT+1, LAT, 0, 32'h0);
    txn("sw",     1'b1, 2'b10, 1'b0, 32'h0C, 32'h6, 32'h0, 1'b0, 2, 0, 1, 32'h00000006);
    txn("lw_sw",  1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h00000006, 1'b0, LAT+1, LAT, 0, 32'h0);
    txn("lw_mis", 1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
    txn("sz11",   1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
    txn("sh_mis", 1'b1, 2'b01, 1'b0, 32'h11, 32'h55, 32'h0, 1'b1, 1, 0, 0, 32'h0);
    txn("lw_aft", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hA5B6C7D8, 1'b0, LAT+1, LAT, 0, 32'h0);

    // Abort a load mid-READ with an asynchronous reset.
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h08;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_read", {31'b0, signal_mem_read}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_read_drop", {31'b0, signal_mem_read}, 32'h0);
    chk("rst_no_resp", {31'b0, resp_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, req_ready}, 32'h1);
    txn("lw_rst", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h11223344, 1'b0, LAT+1, LAT, 0, 32'h0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
